// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : CSR address map and read-select decode shared by the CSR
//               read and write units.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

  // User-level read-only counter aliases
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // Machine-level counter views of the same counters
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_TOHOST    = 12'h51E;

  // Which source feeds the read data register
  typedef enum logic [2:0] {
    SEL_CYCLE_LO   = 3'd0,
    SEL_CYCLE_HI   = 3'd1,
    SEL_INSTRET_LO = 3'd2,
    SEL_INSTRET_HI = 3'd3,
    SEL_HARTID     = 3'd4,
    SEL_TOHOST     = 3'd5,
    SEL_ILLEGAL    = 3'd6
  } csr_sel_e;

  // Map a CSR address to its read source; anything unmapped is illegal
  function automatic csr_sel_e csr_decode(input logic [11:0] addr);
    csr_sel_e sel;
    case (addr)
      CSR_CYCLE,    CSR_MCYCLE:    sel = SEL_CYCLE_LO;
      CSR_CYCLEH,   CSR_MCYCLEH:   sel = SEL_CYCLE_HI;
      CSR_INSTRET,  CSR_MINSTRET:  sel = SEL_INSTRET_LO;
      CSR_INSTRETH, CSR_MINSTRETH: sel = SEL_INSTRET_HI;
      CSR_MHARTID:                 sel = SEL_HARTID;
      CSR_TOHOST:                  sel = SEL_TOHOST;
      default:                     sel = SEL_ILLEGAL;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter
// Description : Free-running wrap-around counter with increment enable.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter #(
  parameter int COUNTER_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [COUNTER_W-1:0] count
);

  logic [COUNTER_W-1:0] count_q;
  logic [COUNTER_W-1:0] count_d;

  // Next count: add one when enabled; all-ones naturally wraps to zero
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + COUNTER_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/csr_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_read_unit
// Description : CSR read path. Owns the cycle and instret counters, decodes
//               the CSR address and returns registered read data one cycle
//               after an un-stalled request.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_read_unit
  import csr_pkg::*;
#(
  parameter int size      = 32,
  parameter int COUNTER_W = 64,
  parameter int HART_ID   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            csr_re,
  input  logic [11:0]     csr_addr,
  input  logic            inst_retire,
  input  logic [size-1:0] tohost_in,
  output logic [size-1:0] csr_rdata,
  output logic            csr_rvalid,
  output logic            csr_illegal
);

  logic [COUNTER_W-1:0] cycle_cnt;
  logic [COUNTER_W-1:0] instret_cnt;
  logic                 instret_inc;

  // A retirement during a stall is not counted; the instruction re-presents
  assign instret_inc = inst_retire & ~stall;

  csr_counter #(.COUNTER_W(COUNTER_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  csr_counter #(.COUNTER_W(COUNTER_W)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_inc),
    .count (instret_cnt)
  );

  csr_sel_e        sel;
  logic [size-1:0] read_val;
  logic [size-1:0] rdata_q,   rdata_d;
  logic            rvalid_q,  rvalid_d;
  logic            illegal_q, illegal_d;

  // Decode the address, select the pre-increment counter value and form
  // the next response; a stall holds the previous response untouched
  always_comb begin
    sel       = csr_decode(csr_addr);
    read_val  = '0;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    illegal_d = illegal_q;

    case (sel)
      SEL_CYCLE_LO:   read_val = cycle_cnt[size-1:0];
      SEL_CYCLE_HI:   read_val = size'(cycle_cnt >> 32);
      SEL_INSTRET_LO: read_val = instret_cnt[size-1:0];
      SEL_INSTRET_HI: read_val = size'(instret_cnt >> 32);
      SEL_HARTID:     read_val = size'(HART_ID);
      SEL_TOHOST:     read_val = tohost_in;
      default:        read_val = '0;
    endcase

    if (!stall) begin
      if (csr_re) begin
        rvalid_d  = 1'b1;
        illegal_d = (sel == SEL_ILLEGAL);
        rdata_d   = read_val;
      end else begin
        rvalid_d  = 1'b0;
        illegal_d = 1'b0;
        rdata_d   = '0;
      end
    end
  end

  // Response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      illegal_q <= illegal_d;
    end
  end

  assign csr_rdata   = rdata_q;
  assign csr_rvalid  = rvalid_q;
  assign csr_illegal = illegal_q;

endmodule
`default_nettype wire
